sumtrig_gen: RTL and testbench

- Parametrised successor to the 16-channel local-sum/trigger block.
- Masks and sums NCH signed local channels, sends the clipped local sum to NX partner FPGAs over the LW-bit comma link, and delays the local sum by a programmable amount.
- Adds the local sum to the partner sums and raises a one-clock trigger request.
- Trigger uses a programmable two-level hysteresis, a programmable deadtime and a veto, and counts the triggers it fires.

---
 rtl/sumtrig_gen.sv | 188 ++++++++++++++++++
 tb/tb_sumtrig_gen.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sumtrig_gen.sv
// sumtrig_gen: masked local channel sum, partner link word, delay line, total sum and trigger.
// Optional SUMTRIG_SAT_EN: saturate the total sum instead of wrapping it.
module sumtrig_gen #(
  parameter int NCH   = 16,
  parameter int DW    = 16,
  parameter int NX    = 3,
  parameter int LW    = 16,
  parameter int SW    = 18,
  parameter int DBITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*DW-1:0]    data,
  input  logic [NCH-1:0]       chmask,
  input  logic [NX*LW-1:0]     xdata,
  input  logic [NX-1:0]        xcomma,
  output logic [LW-1:0]        sumres,
  output logic                 sumcomma,
  input  logic [DBITS-1:0]     xdelay,
  input  logic signed [SW-1:0] thr_hi,
  input  logic signed [SW-1:0] thr_lo,
  input  logic [15:0]          deadtime,
  input  logic                 veto,
  output logic                 trigout,
  output logic [SW-1:0]        sumtot,
  output logic [31:0]          trgcnt,
  output logic                 ovfl
);

  localparam int LG = $clog2(NCH);
  localparam int TW = DW + LG;
  localparam int CW = (TW > LW ? TW : LW) + 1;
  localparam int EW = (SW > LW ? SW : LW) + 4;
  localparam int DN = 2 ** DBITS;
  localparam logic [LW-1:0] K285 = LW'(8'hBC);
  localparam logic signed [CW-1:0] LMAX =
    {{(CW-LW+1){1'b0}}, {(LW-1){1'b1}}};
  localparam logic signed [CW-1:0] LMIN =
    {{(CW-LW+1){1'b1}}, {(LW-1){1'b0}}};

  typedef enum logic {ARMED, HELD} st_e;

  // Heap-ordered tree: leaves at NCH-1.., root at 0, one register level each
  logic signed [TW-1:0] node_q [2*NCH-1];
  logic signed [CW-1:0] lsum_w;
  logic signed [LW-1:0] lclip_d, lclip_q;
  logic                 lclip_ovf;
  logic [LW-1:0]        sumres_q;
  logic                 sumcomma_q;
  logic signed [LW-1:0] dl_q [DN];
  logic [DBITS-1:0]     wp_q;
  logic signed [LW-1:0] dly_w;
  logic signed [EW-1:0] tot_w;
  logic signed [SW-1:0] tot_d, sumtot_q;
  logic                 sat_w;
  logic                 ovfl_q;
  st_e                  st_q, st_d;
  logic [15:0]          dead_q, dead_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 trig_q, trig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2*NCH-1; i++) node_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH-1; i++)
        node_q[i] <= node_q[2*i+1] + node_q[2*i+2];
      for (int i = 0; i < NCH; i++)
        node_q[NCH-1+i] <= chmask[i] ?
          TW'($signed(data[DW*i +: DW])) : '0;
    end
  end

  assign lsum_w = CW'(node_q[0]);

  always_comb begin
    lclip_d   = lsum_w[LW-1:0];
    lclip_ovf = 1'b0;
    if (lsum_w > LMAX) begin
      lclip_d   = LMAX[LW-1:0];
      lclip_ovf = 1'b1;
    end else if (lsum_w < LMIN) begin
      lclip_d   = LMIN[LW-1:0];
      lclip_ovf = 1'b1;
    end
  end

  // Buffer holds the last DN link values; xdelay=0 bypasses it
  assign dly_w = (xdelay == '0) ? lclip_q : dl_q[wp_q - xdelay];

  always_comb begin
    tot_w = EW'(dly_w);
    for (int k = 0; k < NX; k++)
      if (!xcomma[k])
        tot_w = tot_w + EW'($signed(xdata[LW*k +: LW]));
  end

`ifdef SUMTRIG_SAT_EN
  localparam logic signed [EW-1:0] SMAX =
    {{(EW-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN =
    {{(EW-SW+1){1'b1}}, {(SW-1){1'b0}}};

  always_comb begin
    tot_d = tot_w[SW-1:0];
    sat_w = 1'b0;
    if (tot_w > SMAX) begin
      tot_d = SMAX[SW-1:0];
      sat_w = 1'b1;
    end else if (tot_w < SMIN) begin
      tot_d = SMIN[SW-1:0];
      sat_w = 1'b1;
    end
  end
`else
  assign tot_d = tot_w[SW-1:0];
  assign sat_w = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lclip_q    <= '0;
      sumres_q   <= K285;
      sumcomma_q <= 1'b1;
      wp_q       <= '0;
      sumtot_q   <= '0;
      ovfl_q     <= 1'b0;
      for (int i = 0; i < DN; i++) dl_q[i] <= '0;
    end else begin
      lclip_q    <= lclip_d;
      sumres_q   <= (lclip_d == '0) ? K285 : lclip_d;
      sumcomma_q <= (lclip_d == '0);
      dl_q[wp_q] <= lclip_q;
      wp_q       <= wp_q + DBITS'(1);
      sumtot_q   <= tot_d;
      ovfl_q     <= ovfl_q | lclip_ovf | sat_w;
    end
  end

  always_comb begin
    st_d   = st_q;
    dead_d = dead_q;
    cnt_d  = cnt_q;
    trig_d = 1'b0;
    unique case (st_q)
      ARMED: begin
        if (sumtot_q > thr_hi) begin
          st_d = HELD;
          if (!veto) begin
            trig_d = 1'b1;
            cnt_d  = cnt_q + 32'd1;
            dead_d = deadtime;
          end
        end
      end
      HELD: begin
        if (dead_q == '0) begin
          if (sumtot_q <= thr_lo) st_d = ARMED;
        end else begin
          dead_d = dead_q - 16'd1;
        end
      end
      default: st_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ARMED;
      dead_q <= '0;
      cnt_q  <= '0;
      trig_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      dead_q <= dead_d;
      cnt_q  <= cnt_d;
      trig_q <= trig_d;
    end
  end

  assign sumres   = sumres_q;
  assign sumcomma = sumcomma_q;
  assign sumtot   = sumtot_q;
  assign trigout  = trig_q;
  assign trgcnt   = cnt_q;
  assign ovfl     = ovfl_q;

endmodule

// File: tb/tb_sumtrig_gen.sv
// Bench for sumtrig_gen: randomized and directed stimulus,
// expected outputs queued per clock and compared by a separate monitor.
module tb_sumtrig_gen;

  localparam int NCH   = 16;
  localparam int DW    = 16;
  localparam int NX    = 3;
  localparam int LW    = 16;
  localparam int SW    = 18;
  localparam int DBITS = 5;
  localparam int L     = $clog2(NCH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*DW-1:0] data = '0;
  logic [NCH-1:0]    chmask = '0;
  logic [NX*LW-1:0]  xdata = '0;
  logic [NX-1:0]     xcomma = '1;
  logic [LW-1:0]     sumres;
  logic              sumcomma;
  logic [DBITS-1:0]  xdelay = '0;
  logic [SW-1:0]     thr_hi = '0;
  logic [SW-1:0]     thr_lo = '0;
  logic [15:0]       deadtime = '0;
  logic              veto = 1'b0;
  logic              trigout;
  logic [SW-1:0]     sumtot;
  logic [31:0]       trgcnt;
  logic              ovfl;

  sumtrig_gen #(
    .NCH(NCH), .DW(DW), .NX(NX), .LW(LW), .SW(SW), .DBITS(DBITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .chmask(chmask),
    .xdata(xdata), .xcomma(xcomma), .sumres(sumres),
    .sumcomma(sumcomma), .xdelay(xdelay), .thr_hi(thr_hi),
    .thr_lo(thr_lo), .deadtime(deadtime), .veto(veto),
    .trigout(trigout), .sumtot(sumtot), .trgcnt(trgcnt), .ovfl(ovfl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] res;
    logic          comma;
    logic [SW-1:0] tot;
    logic          trg;
    logic [31:0]   cnt;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // stimulus values
  int           ch_v[NCH];
  bit [NCH-1:0] mask_v;
  int           xv[NX];
  bit [NX-1:0]  xc_v;
  int           d_v, hi_v, lo_v, dt_v;
  bit           vt_v;

  // reference model state
  int        e;
  int        lc_hist[$];
  bit        cf_hist[$];
  int        prev_tot;
  bit        armed;
  int        dead;
  bit [31:0] cnt_m;
  bit        ovf_m;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int clipv(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int lc(int n);
    return (n < 1) ? 0 : lc_hist[n-1];
  endfunction

  task automatic model_reset();
    e = 0;
    lc_hist.delete();
    cf_hist.delete();
    prev_tot = 0;
    armed = 1'b1;
    dead = 0;
    cnt_m = '0;
    ovf_m = 1'b0;
  endtask

  task automatic step();
    int   s, t, lv, m;
    exp_t x;
    @(negedge clk);
    for (int i = 0; i < NCH; i++) data[DW*i +: DW] = DW'(ch_v[i]);
    chmask = mask_v;
    for (int k = 0; k < NX; k++) xdata[LW*k +: LW] = LW'(xv[k]);
    xcomma = xc_v;
    xdelay = DBITS'(d_v);
    thr_hi = SW'(hi_v);
    thr_lo = SW'(lo_v);
    deadtime = 16'(dt_v);
    veto = vt_v;
    e++;
    s = 0;
    for (int i = 0; i < NCH; i++) if (mask_v[i]) s += ch_v[i];
    lc_hist.push_back(clipv(s));
    cf_hist.push_back(clipv(s) != s);
    if (e - L >= 1 && cf_hist[e-L-1]) ovf_m = 1'b1;
    lv = lc(e - L);
    x.res = (lv == 0) ? LW'(16'h00BC) : LW'(lv);
    x.comma = (lv == 0);
    t = lc(e - 1 - d_v - L);
    for (int k = 0; k < NX; k++) if (!xc_v[k]) t += xv[k];
`ifdef SUMTRIG_SAT_EN
    if (t > (1 << (SW-1)) - 1) begin
      t = (1 << (SW-1)) - 1;
      ovf_m = 1'b1;
    end else if (t < -(1 << (SW-1))) begin
      t = -(1 << (SW-1));
      ovf_m = 1'b1;
    end
`else
    m = t & ((1 << SW) - 1);
    if (m >= (1 << (SW-1))) m -= (1 << SW);
    t = m;
`endif
    x.trg = 1'b0;
    if (armed) begin
      if (prev_tot > hi_v) begin
        armed = 1'b0;
        if (!vt_v) begin
          x.trg = 1'b1;
          cnt_m++;
          dead = dt_v;
        end
      end
    end else if (dead == 0) begin
      if (prev_tot <= lo_v) armed = 1'b1;
    end else begin
      dead--;
    end
    x.tot = SW'(t);
    x.cnt = cnt_m;
    x.ovf = ovf_m;
    prev_tot = t;
    sb.push_back(x);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_local(int v);
    for (int i = 0; i < NCH; i++) ch_v[i] = 0;
    ch_v[0] = v;
    mask_v = '1;
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_sumres"}, 32'(sumres), 32'h00BC);
    chk({tag, "_sumcomma"}, 32'(sumcomma), 32'd1);
    chk({tag, "_trigout"}, 32'(trigout), 32'd0);
    chk({tag, "_sumtot"}, 32'(sumtot), 32'd0);
    chk({tag, "_trgcnt"}, trgcnt, 32'd0);
    chk({tag, "_ovfl"}, 32'(ovfl), 32'd0);
  endtask

  task automatic safe_defaults();
    set_local(0);
    for (int k = 0; k < NX; k++) xv[k] = 0;
    xc_v = '1;
    d_v = 0;
    hi_v = 10;
    lo_v = 5;
    dt_v = 0;
    vt_v = 1'b0;
  endtask

  task automatic rand_cycles(int n, bit big);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NCH; i++)
        ch_v[i] = big ? int'($urandom_range(65535)) - 32768
                      : int'($urandom_range(120)) - 60;
      mask_v = NCH'($urandom);
      for (int k = 0; k < NX; k++) xv[k] = int'($urandom_range(600)) - 300;
      xc_v = NX'($urandom);
      if ($urandom_range(39) == 0) d_v = int'($urandom_range(31));
      if (c % 100 == 0) begin
        hi_v = int'($urandom_range(400)) - 100;
        lo_v = hi_v - int'($urandom_range(350));
        dt_v = int'($urandom_range(15));
      end
      vt_v = ($urandom_range(9) == 0);
      step();
    end
  endtask

  exp_t mx;
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      mx = sb.pop_front();
      chk("sumres", 32'(sumres), 32'(mx.res));
      chk("sumcomma", 32'(sumcomma), 32'(mx.comma));
      chk("sumtot", 32'(sumtot), 32'(mx.tot));
      chk("trigout", 32'(trigout), 32'(mx.trg));
      chk("trgcnt", trgcnt, mx.cnt);
      chk("ovfl", 32'(ovfl), 32'(mx.ovf));
    end
  end

  initial begin
    int w;
    safe_defaults();
    model_reset();
    @(posedge clk);
    #3;
    chk_reset("init");
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // all channels +1, partners comma
    for (int i = 0; i < NCH; i++) ch_v[i] = 1;
    run(20);

    // alternating +3/-3 gives a zero sum -> comma
    for (int i = 0; i < NCH; i++) ch_v[i] = (i % 2) ? -3 : 3;
    run(12);
    for (int i = 0; i < NCH; i++) ch_v[i] = 0;
    ch_v[0] = 7;
    mask_v = NCH'(1);
    run(12);

    // local step 0 -> 100 seen through a 20-clock delay
    hi_v = 1000;
    set_local(0);
    run(10);
    d_v = 20;
    run(35);
    set_local(100);
    run(40);
    d_v = 0;
    run(40);

    // partners 50, -20, comma; two-level hysteresis
    xv[0] = 50;
    xv[1] = -20;
    xv[2] = 999;
    xc_v = 3'b100;
    hi_v = 40;
    lo_v = 10;
    dt_v = 0;
    for (int r = 0; r < 3; r++) begin
      set_local(30);
      run(8);
      set_local(-22);
      run(8);
    end
    set_local(-40);
    run(8);
    set_local(30);
    run(8);

    // deadtime 100
    set_local(-30);
    run(10);
    dt_v = 100;
    set_local(30);
    run(2);
    set_local(-30);
    run(48);
    set_local(30);
    run(3);
    set_local(-30);
    run(48);
    set_local(30);
    run(6);
    set_local(-30);
    run(10);

    // veto during a crossing
    dt_v = 0;
    vt_v = 1'b1;
    set_local(30);
    run(10);
    vt_v = 1'b0;
    set_local(-30);
    run(10);

    rand_cycles(600, 1'b0);
    rand_cycles(60, 1'b1);

    // mid-stream asynchronous reset
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("mid");
    sb.delete();
    model_reset();
    safe_defaults();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    rand_cycles(200, 1'b0);

    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
